// File: rtl/nmed_accumulator.sv
// nmed_accumulator
//   Error-metric engine for approximate multiplier characterisation. Consumes
//   (exact, approximate) product pairs and accumulates the raw statistics the
//   host needs for MED / NMED / ER:
//     NMED = o_err_sum / o_count / o_max_exact   (division done off-chip)
//
// Ports
//   i_clk, i_rst        clock (rising edge), async active-high reset
//   i_start             begin a new run (only honoured in IDLE/DONE)
//   i_valid / o_ready   sample handshake; accept = i_valid & o_ready
//   i_exact, i_approx   signed PW-bit products
//   i_last              final sample of the run (qualified by accept)
//   o_busy              high in RUN and DRAIN
//   o_done              one-cycle pulse once results are final
//   o_err_sum           saturating sum of |approx - exact|
//   o_max_exact         largest signed exact product seen, floored at 0
//   o_max_abs_err       largest |approx - exact| (unsigned)
//   o_err_count         saturating count of samples with nonzero error
//   o_count             saturating count of accepted samples
module nmed_accumulator #(
  parameter int PW = 16,
  parameter int CW = 17,
  parameter int SW = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic signed [PW-1:0] i_exact,
  input  logic signed [PW-1:0] i_approx,
  input  logic                 i_last,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [SW-1:0]        o_err_sum,
  output logic [PW-1:0]        o_max_exact,
  output logic [PW-1:0]        o_max_abs_err,
  output logic [CW-1:0]        o_err_count,
  output logic [CW-1:0]        o_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state_q;
  logic                 done_q;

  // Stage 1: per-sample error terms
  logic                 s1_vld_q;
  logic [PW-1:0]        s1_abs_q;
  logic                 s1_nz_q;
  logic signed [PW-1:0] s1_exact_q;

  // Stage 2: accumulators
  logic [SW-1:0]        err_sum_q;
  logic signed [PW-1:0] max_exact_q;
  logic [PW-1:0]        max_abs_q;
  logic [CW-1:0]        err_cnt_q;
  logic [CW-1:0]        cnt_q;

  logic                 accept;
  logic [PW:0]          diff_d;
  logic [PW:0]          neg_d;
  logic [PW-1:0]        abs_d;
  logic [SW:0]          sum_ext;
  logic [CW:0]          cnt_ext;
  logic [CW:0]          err_cnt_ext;

  assign accept = i_valid && (state_q == RUN);

  // PW+1 bit difference cannot overflow; its magnitude is at most 2^PW-1,
  // so the low PW bits of the negation are always the exact absolute value.
  always_comb begin
    diff_d = {i_approx[PW-1], i_approx} - {i_exact[PW-1], i_exact};
    neg_d  = ~diff_d + (PW+1)'(1);
    abs_d  = diff_d[PW] ? neg_d[PW-1:0] : diff_d[PW-1:0];
  end

  // One extra carry bit on each accumulator flags saturation.
  always_comb begin
    sum_ext     = {1'b0, err_sum_q} + {{(SW+1-PW){1'b0}}, s1_abs_q};
    cnt_ext     = {1'b0, cnt_q} + (CW+1)'(1);
    err_cnt_ext = {1'b0, err_cnt_q} + (CW+1)'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_abs_q    <= '0;
      s1_nz_q     <= 1'b0;
      s1_exact_q  <= '0;
      err_sum_q   <= '0;
      max_exact_q <= '0;
      max_abs_q   <= '0;
      err_cnt_q   <= '0;
      cnt_q       <= '0;
    end else begin
      // Stage 1
      s1_vld_q <= accept;
      if (accept) begin
        s1_abs_q   <= abs_d;
        s1_nz_q    <= (diff_d != '0);
        s1_exact_q <= i_exact;
      end

      // Stage 2
      if (s1_vld_q) begin
        err_sum_q <= sum_ext[SW] ? '1 : sum_ext[SW-1:0];
        cnt_q     <= cnt_ext[CW] ? '1 : cnt_ext[CW-1:0];
        if (s1_nz_q)
          err_cnt_q <= err_cnt_ext[CW] ? '1 : err_cnt_ext[CW-1:0];
        if (s1_exact_q > max_exact_q) max_exact_q <= s1_exact_q;
        if (s1_abs_q > max_abs_q)     max_abs_q   <= s1_abs_q;
      end

      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (i_start) begin
            // Stage 1 is empty here, so this clear never races an update.
            state_q     <= RUN;
            err_sum_q   <= '0;
            max_exact_q <= '0;
            max_abs_q   <= '0;
            err_cnt_q   <= '0;
            cnt_q       <= '0;
          end else if (state_q == DONE) begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (accept && i_last) state_q <= DRAIN;
        end
        DRAIN: begin
          // Last sample has left stage 1, so accumulators are final now.
          if (!s1_vld_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready       = (state_q == RUN);
  assign o_busy        = (state_q == RUN) || (state_q == DRAIN);
  assign o_done        = done_q;
  assign o_err_sum     = err_sum_q;
  assign o_max_exact   = max_exact_q;
  assign o_max_abs_err = max_abs_q;
  assign o_err_count   = err_cnt_q;
  assign o_count       = cnt_q;

endmodule

// File: tb/tb_nmed_accumulator.sv
module tb_nmed_accumulator;

  logic clk, rst, start, valid, last;
  logic signed [15:0] exact, approx;

  logic        ready, busy, done;
  logic [31:0] err_sum;
  logic [15:0] max_exact, max_abs;
  logic [16:0] err_cnt, cnt;

  logic        s_ready, s_busy, s_done;
  logic [31:0] s_err_sum;
  logic [15:0] s_max_exact, s_max_abs;
  logic [2:0]  s_err_cnt, s_cnt;

  nmed_accumulator #(.PW(16), .CW(17), .SW(32)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_valid(valid), .o_ready(ready),
    .i_exact(exact), .i_approx(approx), .i_last(last), .o_busy(busy), .o_done(done),
    .o_err_sum(err_sum), .o_max_exact(max_exact), .o_max_abs_err(max_abs),
    .o_err_count(err_cnt), .o_count(cnt));

  // Narrow-count instance sharing the same stimulus, for saturation checks.
  nmed_accumulator #(.PW(16), .CW(3), .SW(32)) u_small (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_valid(valid), .o_ready(s_ready),
    .i_exact(exact), .i_approx(approx), .i_last(last), .o_busy(s_busy), .o_done(s_done),
    .o_err_sum(s_err_sum), .o_max_exact(s_max_exact), .o_max_abs_err(s_max_abs),
    .o_err_count(s_err_cnt), .o_count(s_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] sum, cnt, ecnt, maxe, maxa;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  longint m_sum, m_cnt, m_ecnt;
  int     m_maxe, m_maxa;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_sum = 0; m_cnt = 0; m_ecnt = 0; m_maxe = 0; m_maxa = 0;
  endtask

  task automatic do_start();
    model_clear();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives one sample for exactly one rising edge (DUT must be in RUN).
  task automatic send(input logic signed [15:0] e, input logic signed [15:0] a, input logic l);
    int d, ad;
    exp_t x;
    valid = 1'b1; exact = e; approx = a; last = l;
    d  = int'(a) - int'(e);
    ad = (d < 0) ? -d : d;
    m_sum = m_sum + ad;
    if (m_sum > 64'hFFFF_FFFF) m_sum = 64'hFFFF_FFFF;
    m_cnt = (m_cnt + 1 > 131071) ? 131071 : m_cnt + 1;
    if (d != 0) m_ecnt = (m_ecnt + 1 > 131071) ? 131071 : m_ecnt + 1;
    if (int'(e) > m_maxe) m_maxe = int'(e);
    if (ad > m_maxa) m_maxa = ad;
    if (l) begin
      x.sum = 64'(m_sum); x.cnt = 64'(m_cnt); x.ecnt = 64'(m_ecnt);
      x.maxe = 64'(m_maxe); x.maxa = 64'(m_maxa);
      sb.push_back(x);
    end
    @(negedge clk);
    valid = 1'b0; last = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic check_result(input string tag);
    exp_t x;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      x = sb.pop_front();
      chk({tag, "_sum"},  64'(err_sum),   x.sum);
      chk({tag, "_cnt"},  64'(cnt),       x.cnt);
      chk({tag, "_ecnt"}, 64'(err_cnt),   x.ecnt);
      chk({tag, "_maxe"}, 64'(max_exact), x.maxe);
      chk({tag, "_maxa"}, 64'(max_abs),   x.maxa);
    end
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; valid = 1'b0; last = 1'b0; exact = '0; approx = '0;
    model_clear();

    // Reset state
    #3;
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_busy",  64'(busy),  64'd0);
    chk("rst_done",  64'(done),  64'd0);
    chk("rst_sum",   64'(err_sum), 64'd0);
    chk("rst_cnt",   64'(cnt),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 64'(ready), 64'd0);

    // Directed run with exact latency checks
    do_start();
    chk("t1_busy",  64'(busy),  64'd1);
    chk("t1_ready", 64'(ready), 64'd1);
    send(16'sd100, 16'sd98, 1'b0);
    send(-16'sd50, -16'sd50, 1'b0);
    send(16'sd200, 16'sd205, 1'b0);
    send(16'sd0, 16'sd3, 1'b1);
    chk("t1_done_k0", 64'(done), 64'd0);
    chk("t1_ready_drain", 64'(ready), 64'd0);
    @(negedge clk);
    chk("t1_done_k1", 64'(done), 64'd0);
    chk("t1_cnt_k1",  64'(cnt),  64'd4);
    @(negedge clk);
    chk("t1_done_k2", 64'(done), 64'd1);
    chk("t1_sum_const", 64'(err_sum), 64'd10);
    chk("t1_maxe_const", 64'(max_exact), 64'd200);
    check_result("t1");
    chk("t1_busy_after", 64'(busy), 64'd0);

    // Extreme single sample
    do_start();
    send(-16'sd32768, 16'sd32767, 1'b1);
    wait_done("t2");
    chk("t2_maxa_const", 64'(max_abs), 64'd65535);
    check_result("t2");

    // Valid in IDLE has no effect; results held
    valid = 1'b1; last = 1'b1; exact = 16'sd1000; approx = 16'sd0;
    repeat (5) @(negedge clk);
    valid = 1'b0; last = 1'b0;
    chk("t3_hold_cnt", 64'(cnt), 64'd1);
    chk("t3_hold_sum", 64'(err_sum), 64'd65535);
    chk("t3_idle_busy", 64'(busy), 64'd0);
    do_start();
    send(16'sd10, 16'sd12, 1'b0);
    start = 1'b1;                        // ignored in RUN
    @(negedge clk);
    start = 1'b0;
    chk("t3_run_busy", 64'(busy), 64'd1);
    chk("t3_run_cnt",  64'(cnt),  64'd1);
    send(-16'sd7, -16'sd7, 1'b1);
    wait_done("t3");
    chk("t3_cnt_const", 64'(cnt), 64'd2);
    check_result("t3");

    // Saturation of narrow counters
    do_start();
    for (int i = 0; i < 10; i++)
      send(16'(i), 16'(i + 1), (i == 9));
    wait_done("t4");
    chk("t4_small_cnt",  64'(s_cnt),     64'd7);
    chk("t4_small_ecnt", 64'(s_err_cnt), 64'd7);
    chk("t4_small_sum",  64'(s_err_sum), 64'd10);
    check_result("t4");

    // Async reset mid-run
    do_start();
    send(16'sd1, 16'sd2, 1'b0);
    send(16'sd3, 16'sd5, 1'b0);
    send(16'sd4, 16'sd4, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t5_busy",  64'(busy),  64'd0);
    chk("t5_ready", 64'(ready), 64'd0);
    chk("t5_cnt",   64'(cnt),   64'd0);
    chk("t5_sum",   64'(err_sum), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_no_done", 64'(done), 64'd0);
    end

    // Exhaustive 8x8 signed sweep against the model
    do_start();
    for (int a = -128; a < 128; a++) begin
      for (int b = -128; b < 128; b++) begin
        logic signed [15:0] p, q;
        p = 16'(a * b);
        q = p & ~16'sd3;
        send(p, q, (a == 127) && (b == 127));
      end
    end
    wait_done("t6");
    check_result("t6");
    chk("t6_sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
